// File: rtl/spi_cfg_if.sv
// SPI decoder <-> config register bank link: valid/ready write channel and
// fixed-latency read channel.
//   wr_valid/wr_ready/wr_addr/wr_data : write request with handshake
//   rd_valid/rd_addr                  : read request (always accepted)
//   rd_data/rd_data_valid             : read response, one cycle after request
interface spi_cfg_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 12
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;

    // SPI frame decoder side
    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_data, rd_data_valid
    );

    // Register bank side
    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_data, rd_data_valid
    );
endinterface

// File: rtl/spi_cfg_regbank.sv
// Sandpile configuration register bank. Shadow registers are written over SPI
// and copied atomically to the active outputs only while the core is idle.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : write handshake and read channel from the SPI decoder
//   core_idle         : core is between steps, commits allowed
//   run_o, step_o     : free-run enable, single-step pulse
//   reset_software_o  : SRST_CYCLES-long software reset to the core
//   cfg_update_o      : pulse in the cycle the active configuration changes
//   grid_size_o, drop_mode_o, speed_o, random_seed_o : active configuration
//   err_o             : sticky error (bad write address), cleared by STATUS read
module spi_cfg_regbank #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned GRID_W      = 9,
    parameter int unsigned SPEED_W     = 12,
    parameter int unsigned SEED_W      = 10,
    parameter int unsigned GRID_MIN    = 2,
    parameter int unsigned GRID_MAX    = 256,
    parameter int unsigned GRID_DEF    = 8,
    parameter int unsigned SPEED_DEF   = 50,
    parameter int unsigned CHIP_ID     = 'h5A1,
    parameter int unsigned THRESHOLD   = 4,
    parameter int unsigned SRST_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_cfg_if.slave           bus,
    input  logic               core_idle,
    output logic               run_o,
    output logic               step_o,
    output logic               reset_software_o,
    output logic               cfg_update_o,
    output logic [GRID_W-1:0]  grid_size_o,
    output logic               drop_mode_o,
    output logic [SPEED_W-1:0] speed_o,
    output logic [SEED_W-1:0]  random_seed_o,
    output logic               err_o
);

    localparam int unsigned CNT_W = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(SRST_CYCLES - 1);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] A_THR    = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] A_GRID   = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] A_DROP   = ADDR_W'(13);
    localparam logic [ADDR_W-1:0] A_SPEED  = ADDR_W'(14);
    localparam logic [ADDR_W-1:0] A_SEED   = ADDR_W'(15);

    localparam logic [GRID_W-1:0]  GRID_RST  = GRID_W'(GRID_DEF);
    localparam logic [SPEED_W-1:0] SPEED_RST = SPEED_W'(SPEED_DEF);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_COMMIT_WAIT = 2'd1,
        S_SRST        = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;

    logic [GRID_W-1:0]  sh_grid, sh_grid_nx;
    logic               sh_drop, sh_drop_nx;
    logic [SPEED_W-1:0] sh_speed, sh_speed_nx;
    logic [SEED_W-1:0]  sh_seed, sh_seed_nx;

    logic [GRID_W-1:0]  grid_nx;
    logic               drop_nx;
    logic [SPEED_W-1:0] speed_nx;
    logic [SEED_W-1:0]  seed_nx;

    logic               run_nx, step_nx, srst_nx, upd_nx, err_nx;
    logic [DATA_W-1:0]  rd_data_nx;

    logic               wr_fire, ctrl_wr, wr_bad;
    logic               enter_srst, do_commit, run_step;
    logic [GRID_W-1:0]  grid_in, grid_clamped;

    assign bus.wr_ready = (state != S_SRST);
    assign wr_fire      = bus.wr_valid && bus.wr_ready;
    assign ctrl_wr      = wr_fire && (bus.wr_addr == A_CTRL);

    // Clamp incoming grid size into the legal range
    always_comb begin
        grid_in      = bus.wr_data[GRID_W-1:0];
        grid_clamped = grid_in;
        if (32'(grid_in) < GRID_MIN) begin
            grid_clamped = GRID_W'(GRID_MIN);
        end else if (32'(grid_in) > GRID_MAX) begin
            grid_clamped = GRID_W'(GRID_MAX);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        sh_grid_nx  = sh_grid;
        sh_drop_nx  = sh_drop;
        sh_speed_nx = sh_speed;
        sh_seed_nx  = sh_seed;
        grid_nx     = grid_size_o;
        drop_nx     = drop_mode_o;
        speed_nx    = speed_o;
        seed_nx     = random_seed_o;
        run_nx      = run_o;
        step_nx     = 1'b0;
        upd_nx      = 1'b0;
        err_nx      = err_o;
        rd_data_nx  = bus.rd_data;
        wr_bad      = 1'b0;
        enter_srst  = 1'b0;
        do_commit   = 1'b0;
        run_step    = 1'b0;

        // Shadow writes; anything not writable flags an error
        if (wr_fire) begin
            case (bus.wr_addr)
                A_CTRL:  ;
                A_GRID:  sh_grid_nx  = grid_clamped;
                A_DROP:  sh_drop_nx  = bus.wr_data[0];
                A_SPEED: sh_speed_nx = bus.wr_data[SPEED_W-1:0];
                A_SEED:  sh_seed_nx  = bus.wr_data[SEED_W-1:0];
                default: wr_bad      = 1'b1;
            endcase
        end

        // Readback sees pre-write values
        if (bus.rd_valid) begin
            case (bus.rd_addr)
                A_STATUS: rd_data_nx = DATA_W'({err_o, (state == S_COMMIT_WAIT),
                                                (state == S_SRST), run_o});
                A_ID:     rd_data_nx = DATA_W'(CHIP_ID);
                A_THR:    rd_data_nx = DATA_W'(THRESHOLD);
                A_GRID:   rd_data_nx = DATA_W'(sh_grid);
                A_DROP:   rd_data_nx = DATA_W'(sh_drop);
                A_SPEED:  rd_data_nx = DATA_W'(sh_speed);
                A_SEED:   rd_data_nx = DATA_W'(sh_seed);
                default:  rd_data_nx = '0;
            endcase
        end

        // A new error beats the clear-on-read of STATUS
        if (wr_bad) begin
            err_nx = 1'b1;
        end else if (bus.rd_valid && (bus.rd_addr == A_STATUS)) begin
            err_nx = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (ctrl_wr) begin
                    if (bus.wr_data[1]) begin
                        enter_srst = 1'b1;
                    end else if (bus.wr_data[3]) begin
                        if (core_idle) begin
                            do_commit = 1'b1;
                        end else begin
                            state_nx = S_COMMIT_WAIT;
                        end
                    end else begin
                        run_step = 1'b1;
                    end
                end
            end
            S_COMMIT_WAIT: begin
                if (ctrl_wr && bus.wr_data[1]) begin
                    enter_srst = 1'b1;
                end else begin
                    if (ctrl_wr && !bus.wr_data[3]) begin
                        run_step = 1'b1;
                    end
                    if (core_idle) begin
                        do_commit = 1'b1;
                        state_nx  = S_IDLE;
                    end
                end
            end
            S_SRST: begin
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == SRST_LAST) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (run_step) begin
            run_nx  = bus.wr_data[0];
            step_nx = bus.wr_data[2] && !run_o;
        end

        // Commit takes shadow values including a write accepted this cycle
        if (do_commit) begin
            grid_nx  = sh_grid_nx;
            drop_nx  = sh_drop_nx;
            speed_nx = sh_speed_nx;
            seed_nx  = sh_seed_nx;
            upd_nx   = 1'b1;
        end

        if (enter_srst) begin
            state_nx    = S_SRST;
            cnt_nx      = '0;
            sh_grid_nx  = GRID_RST;
            sh_drop_nx  = 1'b0;
            sh_speed_nx = SPEED_RST;
            sh_seed_nx  = '0;
            grid_nx     = GRID_RST;
            drop_nx     = 1'b0;
            speed_nx    = SPEED_RST;
            seed_nx     = '0;
            run_nx      = 1'b0;
            upd_nx      = 1'b1;
        end

        // Software reset output is high exactly while in SRST
        srst_nx = (state_nx == S_SRST);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            sh_grid           <= GRID_RST;
            sh_drop           <= 1'b0;
            sh_speed          <= SPEED_RST;
            sh_seed           <= '0;
            grid_size_o       <= GRID_RST;
            drop_mode_o       <= 1'b0;
            speed_o           <= SPEED_RST;
            random_seed_o     <= '0;
            run_o             <= 1'b0;
            step_o            <= 1'b0;
            reset_software_o  <= 1'b0;
            cfg_update_o      <= 1'b0;
            err_o             <= 1'b0;
            bus.rd_data       <= '0;
            bus.rd_data_valid <= 1'b0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            sh_grid           <= sh_grid_nx;
            sh_drop           <= sh_drop_nx;
            sh_speed          <= sh_speed_nx;
            sh_seed           <= sh_seed_nx;
            grid_size_o       <= grid_nx;
            drop_mode_o       <= drop_nx;
            speed_o           <= speed_nx;
            random_seed_o     <= seed_nx;
            run_o             <= run_nx;
            step_o            <= step_nx;
            reset_software_o  <= srst_nx;
            cfg_update_o      <= upd_nx;
            err_o             <= err_nx;
            bus.rd_data       <= rd_data_nx;
            bus.rd_data_valid <= bus.rd_valid;
        end
    end

endmodule

// File: doc/spi_cfg_regbank.md
Name: spi_cfg_regbank

Overview:
Parametrised successor to the sandpile SPI configuration block. It sits between the SPI slave frame decoder and the sandpile core. It holds shadow configuration registers written over SPI and commits them atomically to the active outputs only when the core is idle. It adds readback, a valid/ready write handshake, a multi-cycle software reset, single-step, grid-size clamping and sticky error status.

Parameters:
ADDR_W, 4, register address width
DATA_W, 12, SPI data word width (must be >= GRID_W, SPEED_W, SEED_W)
GRID_W, 9, grid_size width
SPEED_W, 12, speed width
SEED_W, 10, random_seed width
GRID_MIN, 2, smallest legal grid_size
GRID_MAX, 256, largest legal grid_size
GRID_DEF, 8, grid_size reset/default value
SPEED_DEF, 50, speed reset/default value
CHIP_ID, 12'h5A1, read-only value at address 10
THRESHOLD, 4, read-only topple threshold at address 11
SRST_CYCLES, 4, length of the reset_software_o pulse (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wr_valid  in  1  write request from SPI decoder
wr_ready  out  1  block accepts the write this cycle
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_valid  in  1  read request (always accepted)
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data, zero-extended
rd_data_valid  out  1  rd_data is valid this cycle
core_idle  in  1  sandpile core is between steps; commits are permitted
run_o  out  1  core free-run enable
step_o  out  1  one-cycle single-step pulse
reset_software_o  out  1  software reset to the core, SRST_CYCLES long
cfg_update_o  out  1  one-cycle pulse in the same cycle the active outputs change
grid_size_o  out  GRID_W  active grid size
drop_mode_o  out  1  active drop mode
speed_o  out  SPEED_W  active speed
random_seed_o  out  SEED_W  active seed
err_o  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1) values:
  - run_o, step_o, reset_software_o, cfg_update_o, err_o, rd_data_valid = 0
  - rd_data = 0
  - active and shadow grid = GRID_DEF; drop = 0; speed = SPEED_DEF; seed = 0
  - FSM = IDLE
- Address map:
  - 1 CONTROL (W): bit0 run, bit1 soft reset, bit2 step, bit3 commit.
  - 2 STATUS (R): {err, commit_pending, srst_active, run}. Reading STATUS clears err on the following cycle unless a new error occurs in the same cycle; a new error wins.
  - 10 CHIP_ID (R), 11 THRESHOLD (R).
  - 12-15 shadow grid/drop/speed/seed (R/W). Reads return the shadow value, not the active one.
  - All other addresses are unmapped.
- Write handshake: a write takes effect when wr_valid && wr_ready. wr_ready = 0 in SRST, otherwise 1.
- Writes to 12-15 update the shadow only; active outputs are unchanged.
- Grid write value v is clamped: below GRID_MIN stores GRID_MIN, above GRID_MAX stores GRID_MAX. Only the low GRID_W bits of wr_data are used before clamping.
- Writes to read-only or unmapped addresses: no register changes; err_o goes to 1 on the next cycle.
- CONTROL write priority: soft reset > commit > step/run. When bit1=1, all other bits are ignored.
- FSM:
  - IDLE:
    - CONTROL bit3 with core_idle=1: copy shadow to active on the next edge and pulse cfg_update_o. Stay in IDLE.
    - CONTROL bit3 with core_idle=0: go to COMMIT_WAIT.
    - CONTROL bit1: go to SRST.
  - COMMIT_WAIT:
    - commit_pending = 1.
    - On the first cycle with core_idle=1: copy shadow to active, pulse cfg_update_o, return to IDLE.
    - Shadow writes are still accepted. The commit uses shadow values as of the commit cycle, including a write accepted in that same cycle.
    - A soft reset request cancels the commit and goes to SRST.
  - SRST:
    - Shadow and active registers load their defaults on entry; run_o = 0.
    - reset_software_o = 1 for exactly SRST_CYCLES cycles, counted by an internal counter.
    - cfg_update_o pulses once, on entry.
    - Then return to IDLE.
- run_o follows CONTROL bit0 on a CONTROL write with bit1=0. It is forced to 0 by SRST.
- step_o:
  - A CONTROL write with bit2=1 and run_o=0: one-cycle pulse on the next cycle.
  - With run_o=1: ignored.
- Read: rd_valid at cycle N gives rd_data/rd_data_valid at N+1. Otherwise rd_data_valid=0 and rd_data holds its last value. A read and a write to the same address in the same cycle return the old value.
- Asserting rst mid-SRST or mid-COMMIT_WAIT aborts immediately to reset values.

Test Plan:
- Reset, then read 10 and 11 -> rd_data=12'h5A1 then 4, each one cycle after rd_valid; outputs grid=8, speed=50, seed=0.
- Write 12←20, 14←100, then CONTROL=0x8 with core_idle=1 -> grid_size_o=20 and speed_o=100 on the next cycle, cfg_update_o one pulse; before the commit, outputs stay 8 and 50.
- core_idle=0, CONTROL=0x8, write 15←0x3FF, core_idle=1 three cycles later -> STATUS shows commit_pending; seed=0x3FF appears in the cycle cfg_update_o pulses.
- Write 12←1 then 12←400 -> read 12 returns 2 then 256.
- CONTROL=0x2 while run=1 and wr_valid held -> reset_software_o high exactly 4 cycles, wr_ready=0 for those cycles, run_o=0, all outputs at defaults, held write accepted afterwards.
- Write to address 5 -> err_o=1 with no state change; read STATUS -> bit3=1 returned, err_o=0 one cycle later; CONTROL=0x4 with run=0 -> step_o one-cycle pulse.
